// File: rtl/stream_fifo_th_pkg.sv
// Shared types and constants for the threshold stream FIFO.
// Status fields are sized for occupancies up to 16 bits wide.
package tt_fifo_pkg;

    localparam int DROP_CNT_W     = 8;
    localparam int STATUS_USAGE_W = 16;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef struct packed {
        logic [STATUS_USAGE_W-1:0] usage;
        logic                      almost_full;
        logic                      almost_empty;
    } fifo_status_t;

    function automatic fifo_status_t make_status(
        input logic [STATUS_USAGE_W-1:0] usage,
        input logic [STATUS_USAGE_W-1:0] af_thresh,
        input logic [STATUS_USAGE_W-1:0] ae_thresh
    );
        fifo_status_t s;
        s.usage        = usage;
        s.almost_full  = (usage >= af_thresh);
        s.almost_empty = (usage <= ae_thresh);
        return s;
    endfunction

endpackage

// File: rtl/stream_fifo_th_ptr.sv
// Modulo-DEPTH pointer: advances on en_i, wraps DEPTH-1 -> 0, clr_i wins.
// DEPTH need not be a power of two.
module fifo_ptr #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo_th.sv
// Valid/ready stream FIFO with optional fall-through, optional drop-on-full,
// programmable almost-full/empty thresholds and a saturating drop counter.
module stream_fifo_th
    import tt_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int DEPTH        = 8,
    parameter  bit FALL_THROUGH = 1'b0,
    parameter  bit DROP_ON_FULL = 1'b0,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    input  logic [CW-1:0]         af_thresh_i,
    input  logic [CW-1:0]         ae_thresh_i,
    output logic [CW-1:0]         usage_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         usage_q, usage_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic full, empty, bypass, ft_pass;
    logic push_req, pop_req, push, pop, drop;

    assign full  = (usage_q == CW'(DEPTH));
    assign empty = (usage_q == '0);

    assign in_ready_o  = DROP_ON_FULL ? 1'b1 : !full;
    assign out_valid_o = !empty | (FALL_THROUGH & in_valid_i);

    assign bypass     = FALL_THROUGH & empty;
    assign out_data_o = bypass ? in_data_i : mem_q[rd_ptr];

    // A pop frees a slot this cycle, so a drop-mode push into a full FIFO still lands.
    assign pop_req  = out_valid_o & out_ready_i;
    assign push_req = in_valid_i & in_ready_o & (!full | pop_req);

    // Word passes straight through an empty FIFO: storage and pointers stay put.
    assign ft_pass = bypass & in_valid_i & out_ready_i;

    assign push = push_req & !ft_pass & !flush_i;
    assign pop  = pop_req  & !ft_pass & !flush_i;
    assign drop = DROP_ON_FULL & in_valid_i & full & !pop_req & !flush_i;

    always_comb begin
        usage_d = usage_q;
        if (flush_i) begin
            usage_d = '0;
        end else if (push && !pop) begin
            usage_d = usage_q + 1'b1;
        end else if (pop && !push) begin
            usage_d = usage_q - 1'b1;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            usage_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            usage_q    <= usage_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; usage_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= in_data_i;
        end
    end

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .en_i   (push),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .en_i   (pop),
        .ptr_o  (rd_ptr)
    );

    fifo_status_t status;
    logic         unused_status_usage;

    assign status = make_status(STATUS_USAGE_W'(usage_q),
                                STATUS_USAGE_W'(af_thresh_i),
                                STATUS_USAGE_W'(ae_thresh_i));

    assign usage_o        = status.usage[CW-1:0];
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign drop_cnt_o     = drop_cnt_q;

    // Upper status bits are always zero here; folded away so they read as consumed.
    assign unused_status_usage = ^status.usage;

endmodule

// File: tb/tb_stream_fifo_th.sv
// Directed bench: three DEPTH=4 instances (plain, fall-through, drop-on-full)
// share one stimulus set; each scenario task checks the instance it targets.
module tb_stream_fifo_th;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] af_thresh_i = 3'd3;
    logic [CW-1:0] ae_thresh_i = 3'd1;

    logic [DW-1:0] b_out_data, f_out_data, d_out_data;
    logic          b_in_ready, f_in_ready, d_in_ready;
    logic          b_out_valid, f_out_valid, d_out_valid;
    logic [CW-1:0] b_usage, f_usage, d_usage;
    logic          b_af, f_af, d_af;
    logic          b_ae, f_ae, d_ae;
    logic [7:0]    b_drop, f_drop, d_drop;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    stream_fifo_th #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FALL_THROUGH(1'b0), .DROP_ON_FULL(1'b0)) u_base (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
        .out_data_o(b_out_data), .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
        .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i), .usage_o(b_usage),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .drop_cnt_o(b_drop)
    );

    stream_fifo_th #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FALL_THROUGH(1'b1), .DROP_ON_FULL(1'b0)) u_ft (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(f_in_ready),
        .out_data_o(f_out_data), .out_valid_o(f_out_valid), .out_ready_i(out_ready_i),
        .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i), .usage_o(f_usage),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .drop_cnt_o(f_drop)
    );

    stream_fifo_th #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FALL_THROUGH(1'b0), .DROP_ON_FULL(1'b1)) u_drop (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(d_in_ready),
        .out_data_o(d_out_data), .out_valid_o(d_out_valid), .out_ready_i(out_ready_i),
        .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i), .usage_o(d_usage),
        .almost_full_o(d_af), .almost_empty_o(d_ae), .drop_cnt_o(d_drop)
    );

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic apply_reset();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_data_i   = '0;
        rst_ni      = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill4();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'((i + 1) * 8'h11);
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        fill4();
        in_valid_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd0) begin failures++; $display("FAIL reset_usage got=%0d exp=0", b_usage); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b_out_valid); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", b_in_ready); end
        checks++; if (f_out_valid !== 1'b1) begin failures++; $display("FAIL reset_ft_out_valid got=%b exp=1", f_out_valid); end
        checks++; if (d_drop !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", d_drop); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        apply_reset();
        af_thresh_i = 3'd3;
        ae_thresh_i = 3'd1;
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (b_usage !== 3'(i)) begin failures++; $display("FAIL fill_usage got=%0d exp=%0d", b_usage, i); end
            checks++; if (b_ae !== (i <= 1)) begin failures++; $display("FAIL fill_almost_empty usage=%0d got=%b", i, b_ae); end
            checks++; if (b_af !== (i >= 3)) begin failures++; $display("FAIL fill_almost_full usage=%0d got=%b", i, b_af); end
            in_valid_i = 1'b1;
            in_data_i  = 8'((i + 1) * 8'h11);
            tick();
            checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL fill_latency got=%b exp=1", b_out_valid); end
        end
        in_valid_i = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd4) begin failures++; $display("FAIL full_usage got=%0d exp=4", b_usage); end
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", b_in_ready); end
        checks++; if (b_af !== 1'b1 || b_ae !== 1'b0) begin failures++; $display("FAIL full_flags got=af%b ae%b exp=af1 ae0", b_af, b_ae); end
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL drop_full_in_ready got=%b exp=1", d_in_ready); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'((i + 1) * 8'h11);
            #1;
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== exp) begin failures++; $display("FAIL drain_data got=%h/%b exp=%h/1", b_out_data, b_out_valid, exp); end
            tick();
        end
        out_ready_i = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", b_usage, b_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic       exp_ready;
        apply_reset();
        fill4();
        for (int i = 0; i < 4; i++) q.push_back(8'((i + 1) * 8'h11));
        for (int i = 0; i < 6; i++) begin
            in_data_i   = 8'h50 + 8'(i);
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            #1;
            exp_ready = (q.size() < DEPTH);
            checks++; if (b_in_ready !== exp_ready) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", i, b_in_ready, exp_ready); end
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== q[0]) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, b_out_data, q[0]); end
            void'(q.pop_front());
            if (exp_ready) q.push_back(in_data_i);
            tick();
            checks++; if (b_usage !== 3'(q.size()) || b_usage < 3) begin failures++; $display("FAIL b2b_usage cyc=%0d got=%0d exp=%0d", i, b_usage, q.size()); end
        end
        in_valid_i = 1'b0;
        #1;
        checks++; if (d_usage !== 3'd4 || d_drop !== 8'd0) begin failures++; $display("FAIL drop_pop_makes_room got=%0d/%0d exp=4/0", d_usage, d_drop); end
        while (q.size() > 0) begin
            #1;
            checks++; if (b_out_data !== q[0]) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", b_out_data, q[0]); end
            void'(q.pop_front());
            tick();
        end
        out_ready_i = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd0) begin failures++; $display("FAIL b2b_final_usage got=%0d exp=0", b_usage); end
    endtask

    task automatic test_fall_through();
        apply_reset();
        in_data_i   = 8'hA5;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        #1;
        checks++; if (f_out_valid !== 1'b1 || f_out_data !== 8'hA5) begin failures++; $display("FAIL ft_same_cycle got=%h/%b exp=a5/1", f_out_data, f_out_valid); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL base_no_bypass got=%b exp=0", b_out_valid); end
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        checks++; if (f_usage !== 3'd0 || f_out_valid !== 1'b0) begin failures++; $display("FAIL ft_usage_unchanged got=%0d/%b exp=0/0", f_usage, f_out_valid); end
        checks++; if (b_usage !== 3'd1 || b_out_data !== 8'hA5) begin failures++; $display("FAIL base_one_cycle got=%0d/%h exp=1/a5", b_usage, b_out_data); end
        in_data_i  = 8'h3C;
        in_valid_i = 1'b1;
        #1;
        checks++; if (f_out_valid !== 1'b1 || f_out_data !== 8'h3C) begin failures++; $display("FAIL ft_stalled_view got=%h/%b exp=3c/1", f_out_data, f_out_valid); end
        tick();
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        #1;
        checks++; if (f_usage !== 3'd1 || f_out_data !== 8'h3C) begin failures++; $display("FAIL ft_stored got=%0d/%h exp=1/3c", f_usage, f_out_data); end
    endtask

    task automatic test_drop();
        logic [7:0] exp;
        apply_reset();
        fill4();
        in_data_i  = 8'hEE;
        in_valid_i = 1'b1;
        repeat (300) tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (d_drop !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d exp=255", d_drop); end
        checks++; if (d_usage !== 3'd4 || d_in_ready !== 1'b1) begin failures++; $display("FAIL drop_state got=%0d/%b exp=4/1", d_usage, d_in_ready); end
        checks++; if (b_drop !== 8'd0) begin failures++; $display("FAIL base_no_drop got=%0d exp=0", b_drop); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'((i + 1) * 8'h11);
            #1;
            checks++; if (d_out_data !== exp) begin failures++; $display("FAIL drop_contents got=%h exp=%h", d_out_data, exp); end
            tick();
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_flush_reset();
        apply_reset();
        fill4();
        in_valid_i = 1'b1;
        repeat (3) tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (d_drop !== 8'd3) begin failures++; $display("FAIL pre_flush_drop got=%0d exp=3", d_drop); end
        out_ready_i = 1'b1;
        repeat (2) tick();
        out_ready_i = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd2 || d_usage !== 3'd2) begin failures++; $display("FAIL pre_flush_usage got=%0d/%0d exp=2/2", b_usage, d_usage); end
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL flush_base got=%0d/%b exp=0/0", b_usage, b_out_valid); end
        checks++; if (d_usage !== 3'd0 || d_drop !== 8'd0) begin failures++; $display("FAIL flush_drop got=%0d/%0d exp=0/0", d_usage, d_drop); end
        checks++; if (f_usage !== 3'd0) begin failures++; $display("FAIL flush_ft got=%0d exp=0", f_usage); end
        in_valid_i = 1'b1;
        repeat (3) tick();
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (b_usage !== 3'd0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%b exp=0/0", b_usage, b_out_valid); end
        checks++; if (f_usage !== 3'd0 || f_out_valid !== 1'b1) begin failures++; $display("FAIL async_reset_ft got=%0d/%b exp=0/1", f_usage, f_out_valid); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_fall_through();
        test_drop();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
